// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate-extension unit between decode and ALU/branch
// operand select. Each accepted immediate is extended according to in_mode,
// registered, and presented downstream with a 1-cycle latency. A 2-entry
// skid buffer (output register + skid entry) lets a downstream stall proceed
// without losing an operand. in_ready comes straight from a register.
//
// Modes: 00 zero-extend, 01 sign-extend, 10 upper-place, 11 sign-extend << 2.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   flush            synchronous flush, drops every buffered item
//   in_valid/ready   upstream handshake
//   in_data/mode/tag immediate field, extension mode, sideband tag
//   out_valid/ready  downstream handshake
//   out_data/tag     extended result and its tag
//   xfer_cnt         (only with EXT_PIPE_CNT_EN) 16-bit wrapping count of
//                    completed output transfers, cleared by rst only
//
// Optional feature macro: EXT_PIPE_CNT_EN
module ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
`ifdef EXT_PIPE_CNT_EN
   ,
   output logic [15:0]      xfer_cnt
`endif
);

   // State encoding is {out_valid, skid_valid}, so both handshake outputs
   // are plain register bits.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t             state_p1;
   state_t             state_nx;
   logic               accept_p0;
   logic               xfer_p0;
   logic               load_out_p0;
   logic               load_skid_p0;
   logic               skid_to_out_p0;
   logic [OUT_W-1:0]   ext_p0;
   logic [OUT_W-1:0]   skid_data_p1;
   logic [TAG_W-1:0]   skid_tag_p1;

   function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d,
                                               input logic [1:0]      m);
      logic signed [IN_W-1:0]  ds;
      logic signed [OUT_W-1:0] sx;
      logic [OUT_W-1:0]        res;
      ds = d;
      sx = OUT_W'(ds);
      case (m)
         2'b00:   res = {{(OUT_W-IN_W){1'b0}}, d};
         2'b01:   res = sx;
         2'b10:   res = {d, {(OUT_W-IN_W){1'b0}}};
         default: res = {sx[OUT_W-3:0], 2'b00};
      endcase
      return res;
   endfunction

   // ---- stage p0: input side, combinational extension and control ----
   assign out_valid = state_p1[1];
   assign in_ready  = ~state_p1[0];
   assign accept_p0 = in_valid & in_ready;
   assign xfer_p0   = out_valid & out_ready;
   assign ext_p0    = extend(in_data, in_mode);

   always_comb begin
      state_nx       = state_p1;
      load_out_p0    = 1'b0;
      load_skid_p0   = 1'b0;
      skid_to_out_p0 = 1'b0;
      if (flush) begin
         state_nx = EMPTY;
      end else begin
         case (state_p1)
            EMPTY: begin
               if (accept_p0) begin
                  state_nx    = ONE;
                  load_out_p0 = 1'b1;
               end
            end
            ONE: begin
               if (accept_p0 && xfer_p0) begin
                  load_out_p0 = 1'b1;
               end else if (accept_p0) begin
                  state_nx     = FULL;
                  load_skid_p0 = 1'b1;
               end else if (xfer_p0) begin
                  state_nx = EMPTY;
               end
            end
            FULL: begin
               if (xfer_p0) begin
                  state_nx       = ONE;
                  skid_to_out_p0 = 1'b1;
               end
            end
            default: state_nx = EMPTY;
         endcase
      end
   end

   // ---- stage p1: registered output and skid entry ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p1 <= EMPTY;
      end else begin
         state_p1 <= state_nx;
      end
   end

   // out_data/out_tag must read 0 after reset, so they take the reset too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
         out_tag  <= '0;
      end else if (load_out_p0) begin
         out_data <= ext_p0;
         out_tag  <= in_tag;
      end else if (skid_to_out_p0) begin
         out_data <= skid_data_p1;
         out_tag  <= skid_tag_p1;
      end
   end

   // Skid contents are only meaningful while state_p1 is FULL.
   always_ff @(posedge clk) begin
      if (load_skid_p0) begin
         skid_data_p1 <= ext_p0;
         skid_tag_p1  <= in_tag;
      end
   end

`ifdef EXT_PIPE_CNT_EN
   // A flush wins over a same-edge transfer, so that edge is not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xfer_cnt <= '0;
      end else if (xfer_p0 && !flush) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the CPU datapath, between decode and ALU/branch operand select.
- Supports four extension modes: zero-extend, sign-extend, upper-place (lui-style) and sign-extend with shift-left-by-2 (branch offset).
- Uses valid/ready handshakes on both sides and a 2-entry skid buffer, so a downstream stall never drops an operand.
- Sustains one result per cycle with 1-cycle latency.

Parameters:
- IN_W, 16, width of the input immediate field (min 1).
- OUT_W, 32, width of the extended result. Must satisfy OUT_W >= IN_W + 2.
- TAG_W, 5, width of the sideband tag (destination register number) carried alongside each item.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush; drops all buffered items.
- in_valid  input  1  upstream item present.
- in_ready  output  1  unit can accept an item this cycle.
- in_data  input  IN_W  immediate field.
- in_mode  input  2  00 zero, 01 sign, 10 upper, 11 sign<<2.
- in_tag  input  TAG_W  sideband, passed through unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  OUT_W  extended result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_tag=0, skid entry empty, in_ready=1. These values hold while rst is asserted.
- Accept rule: an item is accepted when in_valid && in_ready at a rising edge.
- Transfer rule: a result is consumed when out_valid && out_ready at a rising edge.
- Extension is computed combinationally on the input side and registered. Buffered entries always hold final OUT_W values.
- Mode 00: {(OUT_W-IN_W) zeros, in_data}.
- Mode 01: {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
- Mode 10: {in_data, (OUT_W-IN_W) zeros}.
- Mode 11: sign-extend to OUT_W-2 bits, then append 2'b00.
- Latency: an item accepted at edge N appears on out_* after edge N (visible in cycle N+1).
- State machine, defined by (out_valid, skid_valid):
  - EMPTY (0,0).
  - ONE (1,0).
  - FULL (1,1).
- EMPTY: accept -> ONE.
- ONE:
  - accept with no transfer -> FULL (new item goes to the skid entry).
  - accept with transfer -> ONE (new item loads the output register).
  - transfer with no accept -> EMPTY.
  - neither -> ONE.
- FULL:
  - transfer -> ONE (skid entry moves to the output register).
  - no transfer -> FULL.
  - No accept is possible in FULL.
- in_ready = !skid_valid, driven from a register with no combinational path from out_ready. in_ready=0 exactly in FULL.
- Ordering is strict FIFO; no item is duplicated or reordered.
- out_data/out_tag hold stable while out_valid && !out_ready.
- flush=1 at an edge: the next state is EMPTY regardless of in_valid/out_ready. Any same-edge accept is discarded and in_ready=1 next cycle. flush has priority over both accept and transfer.
- rst asserted mid-stream: all items are lost immediately. The outputs are the reset values and no stale out_valid remains.
- out_data is not cleared on transfer. Its value is don't-care when out_valid=0, except that it is 0 after reset.

Optional Feature:
- Macro: EXT_PIPE_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [15:0], counting completed output transfers.
  - Increments by 1 per transfer and wraps 0xFFFF -> 0x0000.
  - Cleared by rst only, not by flush.
- Undefined: no xfer_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
- Modes (IN_W=16, OUT_W=32, out_ready=1), in_data=16'h8001:
  - mode 00 -> 32'h0000_8001.
  - mode 01 -> 32'hFFFF_8001.
  - mode 10 -> 32'h8001_0000.
  - mode 11 -> 32'hFFFE_0004.
  - Each result appears 1 cycle after accept.
- Stall: out_ready=0, send tags 1,2,3 back-to-back -> tags 1 and 2 are accepted. in_ready=0 in the cycle after the 2nd accept. Tag 3 is held upstream. After out_ready=1, tags appear in order 1,2,3 with no loss.
- Streaming: 100 items with continuous in_valid/out_ready -> one result per cycle, in_ready stays 1, data matches the reference model.
- Flush: in FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the item offered at the flush edge is never output.
- Async reset: assert rst between clock edges while out_valid=1 -> out_valid=0 and out_data=0 immediately, without a clock. After release, a mode-00 item with data 16'h0005 yields 32'h0000_0005.
- EXT_PIPE_CNT_EN: 65537 transfers -> xfer_cnt=1. A flush mid-run leaves the count unchanged.
